// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register: valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer that registers in_ready, saturating stall counter.
module pipe_stage_skid #(
  parameter int WIDTH = 256,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_stall_cnt;

  generate
    if (SKID != 0) begin : g_skid
      // State encoding is {skid_v, main_v}, so the outputs are plain register bits.
      typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
      } state_t;

      state_t           r_state;
      logic [WIDTH-1:0] r_main;
      logic [WIDTH-1:0] r_skid;
      logic             w_in_xfer;
      logic             w_out_xfer;

      assign w_in_xfer  = i_in_valid & (r_state != ST_FULL);
      assign w_out_xfer = (r_state != ST_EMPTY) & i_out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_EMPTY;
          r_main  <= '0;
          r_skid  <= '0;
        end else if (i_flush) begin
          r_state <= ST_EMPTY;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (w_in_xfer) begin
                r_state <= ST_ONE;
                r_main  <= i_in_data;
              end
            end
            ST_ONE: begin
              if (w_in_xfer && w_out_xfer) begin
                r_main <= i_in_data;
              end else if (w_in_xfer) begin
                r_state <= ST_FULL;
                r_skid  <= i_in_data;
              end else if (w_out_xfer) begin
                r_state <= ST_EMPTY;
              end
            end
            ST_FULL: begin
              if (w_out_xfer) begin
                r_state <= ST_ONE;
                r_main  <= r_skid;
              end
            end
            default: r_state <= ST_EMPTY;
          endcase
        end
      end

      assign o_in_ready  = ~r_state[1];
      assign o_out_valid = r_state[0];
      assign o_out_data  = r_main;
    end else begin : g_noskid
      logic             r_main_v;
      logic [WIDTH-1:0] r_main;
      logic             w_in_ready;
      logic             w_in_xfer;

      // Ready passes straight through from downstream when an entry is held.
      assign w_in_ready = i_out_ready | ~r_main_v;
      assign w_in_xfer  = i_in_valid & w_in_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main_v <= 1'b0;
          r_main   <= '0;
        end else if (i_flush) begin
          r_main_v <= 1'b0;
        end else if (w_in_xfer) begin
          r_main_v <= 1'b1;
          r_main   <= i_in_data;
        end else if (r_main_v && i_out_ready) begin
          r_main_v <= 1'b0;
        end
      end

      assign o_in_ready  = w_in_ready;
      assign o_out_valid = r_main_v;
      assign o_out_data  = r_main;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (o_out_valid && !i_out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule
